// File: rtl/cluster_frame_scheduler_if.sv
// Frame word handshake between the cluster scheduler and its consumer.
interface cluster_frame_scheduler_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [27:0] frame_data;
  logic        frame_first;
  logic        frame_last;
  logic [11:0] frame_bx;
  logic [3:0]  frame_nvalid;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_first,
    output frame_last,
    output frame_bx,
    output frame_nvalid,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_first,
    input  frame_last,
    input  frame_bx,
    input  frame_nvalid,
    output frame_ready
  );
endinterface

// File: rtl/cluster_frame_scheduler.sv
// Bunch-crossing timing, latch strobe and 2-deep cluster frame queue
// serialised as four two-cluster words per frame.
module cluster_frame_scheduler #(
  parameter int BX_MAX = 3563
) (
  input  logic        clock4x,
  input  logic        global_reset_n,
  input  logic        bc0,
  input  logic [1:0]  latch_phase,
  input  logic        drop_empty,
  output logic        latch_out,
  input  logic        clusters_valid,
  input  logic [87:0] adr_in,
  input  logic [23:0] cnt_in,
  output logic [7:0]  overflow_cnt,
  cluster_frame_scheduler_if.master frame
);

  typedef struct packed {
    logic [87:0] adr;
    logic [23:0] cnt;
    logic [11:0] bx;
    logic [3:0]  nvalid;
  } entry_t;

  logic [1:0]  phase;
  logic [11:0] bx;

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      phase     <= '0;
      bx        <= '0;
      latch_out <= 1'b0;
    end else begin
      latch_out <= (phase == latch_phase);
      if (bc0) begin
        phase <= '0;
        bx    <= '0;
      end else begin
        phase <= phase + 2'd1;
        if (phase == 2'd3)
          bx <= (bx == 12'(BX_MAX)) ? '0 : bx + 12'd1;
      end
    end
  end

  // Invalid clusters are blanked on entry so the read side is a plain mux
  entry_t wr;

  always_comb begin
    wr    = '0;
    wr.bx = bx;
    for (int i = 0; i < 8; i++) begin
      if (adr_in[11*i+9 +: 2] != 2'b11) begin
        wr.adr[11*i +: 11] = adr_in[11*i +: 11];
        wr.cnt[3*i +: 3]   = cnt_in[3*i +: 3];
        wr.nvalid          = wr.nvalid + 4'd1;
      end else begin
        wr.adr[11*i +: 11] = 11'h7FF;
      end
    end
  end

  entry_t     mem [2];
  entry_t     head;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] w;
  logic       valid;
  logic       xfer;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       drop;

  assign valid    = (count != 2'd0);
  assign xfer     = valid && frame.frame_ready;
  assign pop      = xfer && (w == 2'd3);
  assign push_req = clusters_valid
                 && !(drop_empty && wr.nvalid == 4'd0);
  assign push     = push_req && (count != 2'd2 || pop);
  assign drop     = push_req && count == 2'd2 && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
      w            <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (xfer)
        w <= w + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  always_comb begin
    frame.frame_valid  = valid;
    frame.frame_data   = '0;
    frame.frame_bx     = '0;
    frame.frame_nvalid = '0;
    frame.frame_first  = 1'b0;
    frame.frame_last   = 1'b0;
    if (valid) begin
      frame.frame_data = {
        head.cnt[6*int'(w)+3 +: 3],
        head.adr[22*int'(w)+11 +: 11],
        head.cnt[6*int'(w) +: 3],
        head.adr[22*int'(w) +: 11]
      };
      frame.frame_bx     = head.bx;
      frame.frame_nvalid = head.nvalid;
      frame.frame_first  = (w == 2'd0);
      frame.frame_last   = (w == 2'd3);
    end
  end

endmodule

// File: tb/tb_cluster_frame_scheduler.sv
// Directed bench for cluster_frame_scheduler: timing, framing,
// back-pressure, overflow and reset behaviour.
module tb_cluster_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        bc0;
  logic [1:0]  latch_phase;
  logic        drop_empty;
  logic        latch_out;
  logic        cv;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic [7:0]  overflow_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  cluster_frame_scheduler_if fif();

  cluster_frame_scheduler dut (
    .clock4x       (clk),
    .global_reset_n(rst_n),
    .bc0           (bc0),
    .latch_phase   (latch_phase),
    .drop_empty    (drop_empty),
    .latch_out     (latch_out),
    .clusters_valid(cv),
    .adr_in        (adr_in),
    .cnt_in        (cnt_in),
    .overflow_cnt  (overflow_cnt),
    .frame         (fif.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  function automatic logic [27:0] exp_word(input int sel, input int w);
    logic [27:0] e;
    e = {3'd0, 11'h7FF, 3'd0, 11'h7FF};
    if (sel == 1) begin
      if (w == 0) e = {3'd2, 11'd5, 3'd1, 11'd0};
      if (w == 1) e = {3'd0, 11'h7FF, 3'd3, 11'd1535};
    end else if (sel == 2) begin
      case (w)
        0: e = {3'd1, 11'd20, 3'd0, 11'd10};
        1: e = {3'd3, 11'd40, 3'd2, 11'd30};
        2: e = {3'd5, 11'd60, 3'd4, 11'd50};
        default: e = {3'd7, 11'd80, 3'd6, 11'd70};
      endcase
    end
    return e;
  endfunction

  task automatic load(input int sel);
    int a1[8] = '{0, 5, 1535, 1536, 2047, 1536, 1700, 2047};
    int c1[8] = '{1, 2, 3, 4, 5, 6, 7, 7};
    for (int i = 0; i < 8; i++) begin
      case (sel)
        1: begin
          adr_in[11*i +: 11] = 11'(a1[i]);
          cnt_in[3*i +: 3]   = 3'(c1[i]);
        end
        2: begin
          adr_in[11*i +: 11] = 11'(10 * (i + 1));
          cnt_in[3*i +: 3]   = 3'(i);
        end
        default: begin
          adr_in[11*i +: 11] = (i % 2 == 0) ? 11'd1536 : 11'd2047;
          cnt_in[3*i +: 3]   = 3'd5;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bc0 = 1'b0; latch_phase = 2'd2; drop_empty = 1'b0;
    cv = 1'b1; adr_in = '0; cnt_in = '0; fif.frame_ready = 1'b0;
    step(); step(); step();
    cv = 1'b0;
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || fif.frame_first !== 1'b0
        || fif.frame_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: v=%b f=%b l=%b want 0 0 0",
               fif.frame_valid, fif.frame_first, fif.frame_last);
    end
    n_cmp++;
    if (fif.frame_data !== 28'd0 || fif.frame_bx !== 12'd0
        || fif.frame_nvalid !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_data: d=%h bx=%0d n=%0d want 0 0 0",
               fif.frame_data, fif.frame_bx, fif.frame_nvalid);
    end
    n_cmp++;
    if (latch_out !== 1'b0 || overflow_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_misc: latch=%b ovf=%0d want 0 0",
               latch_out, overflow_cnt);
    end
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_latch_bx();
    step(); step();
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (latch_out !== ((k % 4) == 3)) begin
        n_bad++;
        $display("FAIL latch k=%0d: got %b want %b",
                 k, latch_out, (k % 4) == 3);
      end
    end
    load(2);
    while (k != 4 * 3563 + 3) step();
    cv = 1'b1;
    step();
    step();
    cv = 1'b0;
    n_cmp++;
    if (fif.frame_bx !== 12'd3563 || fif.frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bx_max: got v=%b bx=%0d want 1 3563",
               fif.frame_valid, fif.frame_bx);
    end
    fif.frame_ready = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (fif.frame_bx !== 12'd0 || fif.frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bx_wrap: got v=%b bx=%0d want 1 0",
               fif.frame_valid, fif.frame_bx);
    end
    repeat (4) step();
    n_cmp++;
    if (fif.frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bx_drain: valid=%b want 0", fif.frame_valid);
    end
  endtask

  task automatic test_format();
    logic [11:0] ebx;
    fif.frame_ready = 1'b1;
    load(1);
    ebx = 12'((k / 4) % 3564);
    cv = 1'b1;
    step();
    cv = 1'b0;
    for (int w = 0; w < 4; w++) begin
      n_cmp++;
      if (fif.frame_valid !== 1'b1 || fif.frame_data !== exp_word(1, w)
          || fif.frame_first !== (w == 0) || fif.frame_last !== (w == 3)
          || fif.frame_nvalid !== 4'd3 || fif.frame_bx !== ebx) begin
        n_bad++;
        $display("FAIL format w%0d: v=%b d=%h f=%b l=%b n=%0d bx=%0d want d=%h n=3 bx=%0d",
                 w, fif.frame_valid, fif.frame_data, fif.frame_first,
                 fif.frame_last, fif.frame_nvalid, fif.frame_bx,
                 exp_word(1, w), ebx);
      end
      step();
    end
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || fif.frame_data !== 28'd0) begin
      n_bad++;
      $display("FAIL format_idle: v=%b d=%h want 0 0",
               fif.frame_valid, fif.frame_data);
    end
  endtask

  task automatic test_stall();
    logic [11:0] ebx;
    fif.frame_ready = 1'b1;
    load(2);
    ebx = 12'((k / 4) % 3564);
    cv = 1'b1;
    step();
    cv = 1'b0;
    step();
    fif.frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (fif.frame_valid !== 1'b1 || fif.frame_data !== exp_word(2, 1)
          || fif.frame_first !== 1'b0 || fif.frame_last !== 1'b0
          || fif.frame_bx !== ebx || fif.frame_nvalid !== 4'd8) begin
        n_bad++;
        $display("FAIL stall c%0d: v=%b d=%h f=%b l=%b bx=%0d n=%0d want d=%h bx=%0d n=8",
                 i, fif.frame_valid, fif.frame_data, fif.frame_first,
                 fif.frame_last, fif.frame_bx, fif.frame_nvalid,
                 exp_word(2, 1), ebx);
      end
      step();
    end
    fif.frame_ready = 1'b1;
    for (int w = 1; w < 4; w++) begin
      n_cmp++;
      if (fif.frame_data !== exp_word(2, w)
          || fif.frame_last !== (w == 3)) begin
        n_bad++;
        $display("FAIL stall_resume w%0d: d=%h l=%b want %h %b",
                 w, fif.frame_data, fif.frame_last, exp_word(2, w), w == 3);
      end
      step();
    end
    n_cmp++;
    if (fif.frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_end: valid=%b want 0", fif.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ebx;
    fif.frame_ready = 1'b0;
    load(1);
    cv = 1'b1;
    step();
    load(2);
    step();
    cv = 1'b0;
    fif.frame_ready = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (fif.frame_last !== 1'b1 || fif.frame_nvalid !== 4'd3) begin
      n_bad++;
      $display("FAIL b2b_last: l=%b n=%0d want 1 3",
               fif.frame_last, fif.frame_nvalid);
    end
    load(1);
    ebx = 12'((k / 4) % 3564);
    cv = 1'b1;
    step();
    cv = 1'b0;
    n_cmp++;
    if (overflow_cnt !== 8'd0 || fif.frame_first !== 1'b1
        || fif.frame_nvalid !== 4'd8
        || fif.frame_data !== exp_word(2, 0)) begin
      n_bad++;
      $display("FAIL b2b_pop_push: ovf=%0d f=%b n=%0d d=%h want 0 1 8 %h",
               overflow_cnt, fif.frame_first, fif.frame_nvalid,
               fif.frame_data, exp_word(2, 0));
    end
    repeat (4) step();
    n_cmp++;
    if (fif.frame_valid !== 1'b1 || fif.frame_nvalid !== 4'd3
        || fif.frame_bx !== ebx || fif.frame_data !== exp_word(1, 0)) begin
      n_bad++;
      $display("FAIL b2b_third: v=%b n=%0d bx=%0d d=%h want 1 3 %0d %h",
               fif.frame_valid, fif.frame_nvalid, fif.frame_bx,
               fif.frame_data, ebx, exp_word(1, 0));
    end
    repeat (4) step();
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || overflow_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL b2b_end: v=%b ovf=%0d want 0 0",
               fif.frame_valid, overflow_cnt);
    end
  endtask

  task automatic test_drop_empty();
    fif.frame_ready = 1'b1;
    drop_empty = 1'b1;
    load(3);
    cv = 1'b1;
    step();
    cv = 1'b0;
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || overflow_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL drop_empty: v=%b ovf=%0d want 0 0",
               fif.frame_valid, overflow_cnt);
    end
    drop_empty = 1'b0;
    cv = 1'b1;
    step();
    cv = 1'b0;
    for (int w = 0; w < 4; w++) begin
      n_cmp++;
      if (fif.frame_valid !== 1'b1 || fif.frame_nvalid !== 4'd0
          || fif.frame_data !== exp_word(3, w)
          || fif.frame_first !== (w == 0) || fif.frame_last !== (w == 3)) begin
        n_bad++;
        $display("FAIL keep_empty w%0d: v=%b n=%0d d=%h f=%b l=%b want n=0 d=%h",
                 w, fif.frame_valid, fif.frame_nvalid, fif.frame_data,
                 fif.frame_first, fif.frame_last, exp_word(3, w));
      end
      step();
    end
  endtask

  task automatic test_overflow();
    fif.frame_ready = 1'b0;
    cv = 1'b1;
    load(1);
    step();
    load(2);
    step();
    load(1);
    step();
    cv = 1'b0;
    n_cmp++;
    if (overflow_cnt !== 8'd1 || fif.frame_nvalid !== 4'd3) begin
      n_bad++;
      $display("FAIL ovf_one: ovf=%0d n=%0d want 1 3",
               overflow_cnt, fif.frame_nvalid);
    end
    cv = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) begin
        n_cmp++;
        if (overflow_cnt !== 8'd101) begin
          n_bad++;
          $display("FAIL ovf_101: got %0d want 101", overflow_cnt);
        end
      end
    end
    cv = 1'b0;
    n_cmp++;
    if (overflow_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL ovf_sat: got %0d want 255", overflow_cnt);
    end
    fif.frame_ready = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (fif.frame_nvalid !== 4'd8 || fif.frame_data !== exp_word(2, 0)
        || fif.frame_first !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_second: n=%0d d=%h f=%b want 8 %h 1",
               fif.frame_nvalid, fif.frame_data, fif.frame_first,
               exp_word(2, 0));
    end
    repeat (4) step();
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || overflow_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL ovf_end: v=%b ovf=%0d want 0 255",
               fif.frame_valid, overflow_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    fif.frame_ready = 1'b1;
    load(2);
    cv = 1'b1;
    step();
    cv = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fif.frame_valid !== 1'b0 || fif.frame_data !== 28'd0
        || fif.frame_bx !== 12'd0 || fif.frame_nvalid !== 4'd0
        || latch_out !== 1'b0 || overflow_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_async: v=%b d=%h bx=%0d n=%0d latch=%b ovf=%0d want all 0",
               fif.frame_valid, fif.frame_data, fif.frame_bx,
               fif.frame_nvalid, latch_out, overflow_cnt);
    end
    step(); step();
    latch_phase = 2'd0;
    rst_n = 1'b1;
    k = 0;
    load(1);
    cv = 1'b1;
    step();
    cv = 1'b0;
    n_cmp++;
    if (latch_out !== 1'b1 || fif.frame_first !== 1'b1
        || fif.frame_data !== exp_word(1, 0) || fif.frame_bx !== 12'd0
        || fif.frame_nvalid !== 4'd3) begin
      n_bad++;
      $display("FAIL rst_resume: latch=%b f=%b d=%h bx=%0d n=%0d want 1 1 %h 0 3",
               latch_out, fif.frame_first, fif.frame_data, fif.frame_bx,
               fif.frame_nvalid, exp_word(1, 0));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (latch_out !== (k == 5)) begin
        n_bad++;
        $display("FAIL rst_latch k=%0d: got %b want %b",
                 k, latch_out, k == 5);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latch_bx();
    test_format();
    test_stall();
    test_back_to_back();
    test_drop_empty();
    test_overflow();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cluster_frame_scheduler.md
CLUSTER_FRAME_SCHEDULER -- requirements
Module: cluster_frame_scheduler

Interface
REQ-001 SHALL have parameter BX_MAX, default 3563, meaning the last bunch-crossing count before bx wraps to 0.
REQ-002 SHALL have port clock4x  input  1  the 160 MHz clock, 4 cycles per bunch crossing.
REQ-003 SHALL have port global_reset_n  input  1  the reset: asynchronous, active-low.
REQ-004 SHALL have port bc0  input  1  the bunch-crossing-zero strobe.
REQ-005 SHALL have port latch_phase  input  2  the phase at which the datapath latch strobe fires.
REQ-006 SHALL have port drop_empty  input  1  when set, frames with zero valid clusters are discarded.
REQ-007 SHALL have port latch_out  output  1  the one-cycle latch strobe to the 1536-strip priority datapath.
REQ-008 SHALL have port clusters_valid  input  1  a one-cycle pulse meaning adr_in/cnt_in hold a new set of 8 clusters.
REQ-009 SHALL have port adr_in  input  88  holding cluster i address at [11i+10:11i].
REQ-010 SHALL have port cnt_in  input  24  holding cluster i count at [3i+2:3i].
REQ-011 SHALL have port frame_valid  output  1  meaning a frame word is offered.
REQ-012 SHALL have port frame_ready  input  1  the downstream accept signal.
REQ-013 SHALL have port frame_data  output  28  holding two clusters per word.
REQ-014 SHALL have port frame_first / frame_last  output  1 each  marking word 0 and word 3 of a frame.
REQ-015 SHALL have port frame_bx  output  12  the bx tag of the current frame.
REQ-016 SHALL have port frame_nvalid  output  4  the valid-cluster count of the current frame (0..8).
REQ-017 SHALL have port overflow_cnt  output  8  a saturating count of dropped frames.

Function
REQ-018 SHALL keep phase (2 bits) and bx (12 bits) counters. bc0=1 in cycle N gives phase=0, bx=0 in N+1. Otherwise phase increments each cycle. On the phase 3->0 wrap, bx increments, and bx=BX_MAX wraps to 0.
REQ-019 SHALL register latch_out high in cycle N+1 if and only if phase==latch_phase in cycle N.
REQ-020 SHALL treat cluster i as valid if and only if its adr_in field is < 1536. nvalid is the count of valid clusters.
REQ-021 SHALL, on clusters_valid, form an entry {adr, cnt, bx at that cycle, nvalid} and write it to a 2-entry FIFO.
REQ-022 SHALL not store an entry with nvalid==0 while drop_empty=1, and SHALL not count such an entry as overflow.
REQ-023 SHALL drop the entry when clusters_valid arrives with the FIFO full, unless the final word (word 3) of the head frame is transferred that same cycle, in which case the entry is accepted.
REQ-024 SHALL increment overflow_cnt on each drop, saturating at 255.
REQ-025 SHALL assert frame_valid whenever the FIFO is non-empty. A transfer occurs on frame_valid && frame_ready.
REQ-026 SHALL sequence each head entry through word index w = 0,1,2,3. Each transfer advances w. The transfer at w=3 pops the entry and resets w to 0.
REQ-027 SHALL format frame_data as: [13:0] = {cnt, adr} of cluster 2w; [27:14] = {cnt, adr} of cluster 2w+1.
REQ-028 SHALL replace invalid clusters in frame_data with adr=11'h7FF, cnt=0.
REQ-029 SHALL assert frame_first when w==0 and frame_last when w==3, both qualified by frame_valid.
REQ-030 SHALL drive frame_bx and frame_nvalid from the head entry, held for all 4 words.
REQ-031 SHALL hold all frame_* outputs stable while frame_valid=1 and frame_ready=0.
REQ-032 SHALL drive frame_data, frame_bx and frame_nvalid as 0 when frame_valid=0.
REQ-033 SHALL have zero-cycle latency from FIFO write to frame_valid: it asserts in the cycle after clusters_valid.

Reset
REQ-034 SHALL, while global_reset_n=0, hold phase=0, bx=0, latch_out=0, FIFO empty, w=0, frame_valid=0, frame_first=0, frame_last=0, frame_data=0, frame_bx=0, frame_nvalid=0, overflow_cnt=0.
REQ-035 SHALL discard any partially sent frame on reset assertion mid-frame; after release the first frame sent starts at w=0.
REQ-036 SHALL resume counting from phase=0 in the first cycle after global_reset_n rises.

Verification
REQ-037 SHALL cover this scenario: reset release, latch_phase=2, bc0 pulse -> latch_out high every 4th cycle, 3 cycles after bc0; bx increments every 4 cycles and wraps 3563->0.
REQ-038 SHALL cover this scenario: clusters_valid with adr={0,5,1535,1536,2047,...}, frame_ready=1 -> 4 consecutive words; cluster 3 and cluster 4 emitted as 7FF/0; frame_nvalid=3; frame_first on word 0, frame_last on word 3.
REQ-039 SHALL cover this scenario: frame_ready=0 for 10 cycles mid-frame -> frame_data, frame_bx and w frozen; transfer resumes at the same word.
REQ-040 SHALL cover this scenario: frame_ready=0 and 3 clusters_valid pulses -> 2 entries stored, overflow_cnt=1; with 300 further drops, overflow_cnt saturates at 255.
REQ-041 SHALL cover this scenario: FIFO full, word 3 accepted in the same cycle as clusters_valid -> new entry stored, overflow_cnt unchanged.
REQ-042 SHALL cover this scenario: drop_empty=1 with all adr>=1536 -> no frame and no overflow. Repeated with drop_empty=0 -> frame with nvalid=0 and all words 7FF/0.
